ttt_turn_controller: RTL and testbench

//  Game sequencer for the tic-tac-toe datapath. Owns the 3x3 board and the

---
 rtl/ttt_turn_controller.sv | 189 ++++++++++++++++++
 tb/tb_ttt_turn_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe game sequencer: owns the board and turn bit, arbitrates X/O moves, detects win/draw.
// Optional per-turn move timeout is compiled in with `define TTT_MOVE_TIMEOUT_EN.
module ttt_turn_controller #(
  parameter logic        FIRST_PLAYER   = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        new_game_i,
  input  logic        req_x_i,
  input  logic [3:0]  cell_x_i,
  input  logic        req_o_i,
  input  logic [3:0]  cell_o_i,
  output logic        ack_x_o,
  output logic        nack_x_o,
  output logic        ack_o_o,
  output logic        nack_o_o,
  output logic        turn_o,
  output logic [17:0] board_o,
  output logic        game_over_o,
  output logic [1:0]  winner_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {StPlay, StCheck, StOver} state_e;

  state_e      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic        turn_q, turn_d;
  logic [3:0]  move_cnt_q, move_cnt_d;
  logic [1:0]  winner_q, winner_d;
  logic        game_over_q, game_over_d;
  logic        ack_x_q, ack_x_d, nack_x_q, nack_x_d;
  logic        ack_o_q, ack_o_d, nack_o_q, nack_o_d;
  logic        timeout_q, timeout_d;

  logic       req_on, req_off, cell_ok, cell_free, accept, win, tmo_hit;
  logic [3:0] cell_on, cell_idx;
  logic [1:0] mover;
  logic       on_ack, on_nack, off_nack;

  function automatic logic owns3(logic [17:0] b, logic [1:0] c, int unsigned p0,
                                 int unsigned p1, int unsigned p2);
    return (b[2*p0 +: 2] == c) && (b[2*p1 +: 2] == c) && (b[2*p2 +: 2] == c);
  endfunction

  assign req_on    = turn_q ? req_o_i : req_x_i;
  assign req_off   = turn_q ? req_x_i : req_o_i;
  assign cell_on   = turn_q ? cell_o_i : cell_x_i;
  assign mover     = turn_q ? 2'b10 : 2'b01;
  assign cell_ok   = (cell_on <= 4'd8);
  // Out-of-range cells are folded to 0 so the board select stays in range.
  assign cell_idx  = cell_ok ? cell_on : 4'd0;
  assign cell_free = (board_q[{cell_idx, 1'b0} +: 2] == 2'b00);
  assign accept    = (state_q == StPlay) && req_on && cell_ok && cell_free;

  assign win = owns3(board_q, mover, 0, 1, 2) | owns3(board_q, mover, 3, 4, 5) |
               owns3(board_q, mover, 6, 7, 8) | owns3(board_q, mover, 0, 3, 6) |
               owns3(board_q, mover, 1, 4, 7) | owns3(board_q, mover, 2, 5, 8) |
               owns3(board_q, mover, 0, 4, 8) | owns3(board_q, mover, 2, 4, 6);

`ifdef TTT_MOVE_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (state_q == StPlay) && !accept && (tmo_cnt_q == TmoLast);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
    if (new_game_i || (state_q != StPlay) || accept || tmo_hit) begin
      tmo_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StPlay;
      board_q     <= '0;
      turn_q      <= FIRST_PLAYER;
      move_cnt_q  <= '0;
      winner_q    <= 2'b00;
      game_over_q <= 1'b0;
      ack_x_q     <= 1'b0;
      nack_x_q    <= 1'b0;
      ack_o_q     <= 1'b0;
      nack_o_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      turn_q      <= turn_d;
      move_cnt_q  <= move_cnt_d;
      winner_q    <= winner_d;
      game_over_q <= game_over_d;
      ack_x_q     <= ack_x_d;
      nack_x_q    <= nack_x_d;
      ack_o_q     <= ack_o_d;
      nack_o_q    <= nack_o_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (new_game_i) begin
      state_d = StPlay;
    end else begin
      unique case (state_q)
        StPlay:  if (accept) state_d = StCheck;
        StCheck: state_d = (win || (move_cnt_q == 4'd9)) ? StOver : StPlay;
        StOver:  state_d = StOver;
        default: state_d = StPlay;
      endcase
    end
  end

  always_comb begin
    board_d     = board_q;
    turn_d      = turn_q;
    move_cnt_d  = move_cnt_q;
    winner_d    = winner_q;
    game_over_d = (state_d == StOver);
    timeout_d   = 1'b0;
    on_ack      = 1'b0;
    on_nack     = 1'b0;
    off_nack    = 1'b0;
    if (new_game_i) begin
      board_d    = '0;
      turn_d     = FIRST_PLAYER;
      move_cnt_d = '0;
      winner_d   = 2'b00;
    end else begin
      unique case (state_q)
        StPlay: begin
          off_nack = req_off;
          if (accept) begin
            board_d[{cell_idx, 1'b0} +: 2] = mover;
            move_cnt_d = move_cnt_q + 4'd1;
            on_ack     = 1'b1;
          end else begin
            on_nack = req_on;
          end
          if (tmo_hit) begin
            turn_d    = ~turn_q;
            timeout_d = 1'b1;
          end
        end
        StCheck: begin
          on_nack  = req_on;
          off_nack = req_off;
          if (win)                      winner_d = mover;
          else if (move_cnt_q == 4'd9)  winner_d = 2'b11;
          else                          turn_d   = ~turn_q;
        end
        default: begin
          on_nack  = req_on;
          off_nack = req_off;
        end
      endcase
    end
    ack_x_d  = ~turn_q & on_ack;
    ack_o_d  = turn_q & on_ack;
    nack_x_d = turn_q ? off_nack : on_nack;
    nack_o_d = turn_q ? on_nack : off_nack;
  end

  assign ack_x_o     = ack_x_q;
  assign nack_x_o    = nack_x_q;
  assign ack_o_o     = ack_o_q;
  assign nack_o_o    = nack_o_q;
  assign turn_o      = turn_q;
  assign board_o     = board_q;
  assign game_over_o = game_over_q;
  assign winner_o    = winner_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Bench for ttt_turn_controller: game-rule model compared every cycle plus directed literal checks.
module tb_ttt_turn_controller;

  logic        clk = 1'b0;
  logic        rst, new_game, req_x, req_o;
  logic [3:0]  cell_x, cell_o;
  logic        ack_x, nack_x, ack_o, nack_o, turn, game_over, timeout;
  logic [17:0] board;
  logic [1:0]  winner;

  always #5 clk = ~clk;

  ttt_turn_controller #(
    .FIRST_PLAYER  (1'b0),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .new_game_i (new_game),
    .req_x_i    (req_x),
    .cell_x_i   (cell_x),
    .req_o_i    (req_o),
    .cell_o_i   (cell_o),
    .ack_x_o    (ack_x),
    .nack_x_o   (nack_x),
    .ack_o_o    (ack_o),
    .nack_o_o   (nack_o),
    .turn_o     (turn),
    .board_o    (board),
    .game_over_o(game_over),
    .winner_o   (winner),
    .timeout_o  (timeout)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Game model: board as cells, a pending-check flag and an over flag.
  logic [1:0] m_board[9];
  bit         m_turn, m_over, m_pending;
  int         m_moves, m_tmo;
  logic [1:0] m_winner;
  bit         e_ack_x, e_nack_x, e_ack_o, e_nack_o, e_tmo;
  int         lines[8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                              '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};
  bit         r_on, r_off, acc;
  int         c_on;
  logic [1:0] who;

  function automatic bit has_line(logic [1:0] p);
    for (int l = 0; l < 8; l++)
      if (m_board[lines[l][0]] == p && m_board[lines[l][1]] == p && m_board[lines[l][2]] == p)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 9; i++) m_board[i] = 2'b00;
    m_turn = 1'b0; m_over = 1'b0; m_pending = 1'b0;
    m_moves = 0; m_tmo = 0; m_winner = 2'b00;
    e_ack_x = 0; e_nack_x = 0; e_ack_o = 0; e_nack_o = 0; e_tmo = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst || new_game) begin
      m_clear();
    end else begin
      e_ack_x = 0; e_nack_x = 0; e_ack_o = 0; e_nack_o = 0; e_tmo = 0;
      who = m_turn ? 2'b10 : 2'b01;
      if (m_over) begin
        e_nack_x = req_x; e_nack_o = req_o;
      end else if (m_pending) begin
        e_nack_x = req_x; e_nack_o = req_o;
        m_pending = 1'b0;
        if (has_line(who)) begin
          m_over = 1'b1; m_winner = who;
        end else if (m_moves == 9) begin
          m_over = 1'b1; m_winner = 2'b11;
        end else begin
          m_turn = ~m_turn; m_tmo = 0;
        end
      end else begin
        r_on  = m_turn ? req_o : req_x;
        r_off = m_turn ? req_x : req_o;
        c_on  = m_turn ? int'(cell_o) : int'(cell_x);
        acc   = 1'b0;
        if (r_off) begin
          if (m_turn) e_nack_x = 1; else e_nack_o = 1;
        end
        if (r_on) begin
          if (c_on <= 8 && m_board[c_on] == 2'b00) begin
            m_board[c_on] = who;
            m_moves++;
            m_pending = 1'b1;
            m_tmo = 0;
            acc = 1'b1;
            if (m_turn) e_ack_o = 1; else e_ack_x = 1;
          end else begin
            if (m_turn) e_nack_o = 1; else e_nack_x = 1;
          end
        end
`ifdef TTT_MOVE_TIMEOUT_EN
        if (!acc) begin
          if (m_tmo == 7) begin
            e_tmo = 1; m_turn = ~m_turn; m_tmo = 0;
          end else begin
            m_tmo++;
          end
        end
`endif
      end
    end
  end

  logic [17:0] exp_board;
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 9; i++) exp_board[2*i +: 2] = m_board[i];
      check("cycle_outputs",
            32'({ack_x, nack_x, ack_o, nack_o, turn, game_over, winner, timeout, board}),
            32'({e_ack_x, e_nack_x, e_ack_o, e_nack_o, m_turn, m_over,
                 (m_over ? m_winner : 2'b00), e_tmo, exp_board}));
    end
  end

  task automatic cyc(input bit rx, input int cx, input bit ro, input int co, input bit ng);
    @(negedge clk);
    req_x = rx; cell_x = 4'(cx); req_o = ro; cell_o = 4'(co); new_game = ng;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  int draw_seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

  initial begin
    rst = 1'b1; new_game = 0; req_x = 0; req_o = 0; cell_x = '0; cell_o = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;
    check("reset_state",
          32'({ack_x, nack_x, ack_o, nack_o, turn, game_over, winner, timeout, board}), 32'd0);

    cyc(1, 4, 0, 0, 0); settle;
    check("t1_ack_x", 32'({ack_x, nack_x, turn, board}), 32'({3'b100, 18'h00100}));
    idle(1); settle;
    check("t1_turn", 32'(turn), 32'd1);

    cyc(0, 0, 1, 4, 0); settle;
    check("t2_nack_o", 32'({nack_o, ack_o, turn, board}), 32'({3'b101, 18'h00100}));
    cyc(0, 0, 1, 0, 0); idle(1);

    cyc(1, 8, 1, 3, 0); settle;
    check("t3_both_req", 32'({ack_x, nack_o, ack_o, nack_x}), 32'(4'b1100));
    idle(1); settle;
    check("t3_board", 32'({turn, board}), 32'({1'b1, 18'h10102}));

    cyc(0, 0, 1, 9, 0); settle;
    check("cell9_nack", 32'({nack_o, board}), 32'({1'b1, 18'h10102}));
    cyc(0, 0, 1, 15, 0);
    cyc(0, 0, 1, 8, 0); settle;
    check("occupied_nack", 32'({nack_o, turn}), 32'(2'b11));
    cyc(1, 5, 0, 0, 0); settle;
    check("offturn_nack_x", 32'({nack_x, ack_x}), 32'(2'b10));

    cyc(1, 0, 1, 0, 1); settle;
    check("ng_clear", 32'({ack_x, nack_x, ack_o, nack_o, turn, board}), 32'd0);

    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 6, 0); settle;
    check("check_state_nack", 32'({nack_o, ack_o}), 32'(2'b10));
    cyc(0, 0, 1, 3, 0); idle(1);
    cyc(1, 1, 0, 0, 0); idle(1);
    cyc(0, 0, 1, 4, 0); idle(1);
    cyc(1, 2, 0, 0, 0); settle;
    check("t4_not_over_yet", 32'({ack_x, game_over}), 32'(2'b10));
    idle(1); settle;
    check("t4_win", 32'({game_over, winner, board}), 32'({3'b101, 18'h00295}));
    cyc(0, 0, 1, 5, 0); settle;
    check("t4_over_nack", 32'({nack_o, ack_o, board}), 32'({2'b10, 18'h00295}));
    cyc(1, 5, 0, 0, 0); idle(2);

    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) cyc(1, draw_seq[i], 0, 0, 0);
      else            cyc(0, 0, 1, draw_seq[i], 0);
      idle(1);
    end
    settle;
    check("t5_draw", 32'({game_over, winner, board}), 32'({3'b111, 18'h16A59}));
    cyc(0, 0, 0, 0, 1); settle;
    check("t5_new_game", 32'({game_over, winner, turn, board}), 32'd0);

`ifdef TTT_MOVE_TIMEOUT_EN
    idle(7); settle;
    check("t6_no_timeout_yet", 32'({timeout, turn}), 32'd0);
    idle(1); settle;
    check("t6_timeout", 32'({timeout, turn, board}), 32'({2'b11, 18'h0}));
    idle(1); settle;
    check("t6_pulse_end", 32'({timeout, turn}), 32'(2'b01));
`endif

    idle(3);
    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
